// File: rtl/isqrt_pkg.sv
// Shared types and widths for the 16-bit integer square-root block.
package isqrt_pkg;

  localparam int RAD_W  = 16;
  localparam int ROOT_W = 8;
  localparam int REM_W  = 9;
  localparam int ITER   = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [REM_W:0]    i_rem,
  input  logic [ROOT_W-1:0] i_root,
  input  logic [1:0]        i_pair,
  output logic [REM_W:0]    o_rem,
  output logic [ROOT_W-1:0] o_root
);

  // The partial remainder never exceeds 2*root, so the shifted value stays
  // below 1024; 12 signed bits leave headroom for the sign of the trial.
  logic signed [11:0] w_shift;
  logic signed [11:0] w_sub;
  logic signed [11:0] w_trial;
  logic               w_ge;

  assign w_shift = {i_rem, i_pair};
  assign w_sub   = {2'b00, i_root, 2'b01};
  assign w_trial = w_shift - w_sub;
  assign w_ge    = ~w_trial[11];

  // Keep the trial when non-negative, otherwise restore the shifted remainder.
  assign o_rem  = (REM_W + 1)'(w_ge ? w_trial : w_shift);
  assign o_root = ROOT_W'({i_root, w_ge});

endmodule

// File: rtl/isqrt_16bit.sv
// Sequential 16-bit integer square root: 8 iterations, registered results.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | one root bit resolved per cycle, counter 0..7
// DONE  | done pulse for one cycle; start here begins a new request
module isqrt_16bit
  import isqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAD_W-1:0]  Y,
  output logic              busy,
  output logic              done,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem
);

  state_t             r_state;
  logic [RAD_W-1:0]   r_rad;
  logic [REM_W:0]     r_rem;
  logic [ROOT_W-1:0]  r_root;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [ROOT_W-1:0]  r_root_out;
  logic [REM_W-1:0]   r_rem_out;

  logic [REM_W:0]     w_rem_nxt;
  logic [ROOT_W-1:0]  w_root_nxt;

  // The radicand register shifts left two bits per iteration, so the next
  // pair is always its top two bits.
  isqrt_step u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_pair (r_rad[RAD_W-1 -: 2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_root_out <= '0;
      r_rem_out  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_rad   <= Y;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITER - 1)) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_root_out <= w_root_nxt;
            r_rem_out  <= REM_W'(w_rem_nxt);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign root = r_root_out;
  assign rem  = r_rem_out;

endmodule

// File: tb/tb_isqrt_16bit.sv
// Scoreboard bench for isqrt_16bit: stimulus pushes expectations, monitor pops on done.
module tb_isqrt_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] Y;
  logic        busy;
  logic        done;
  logic [7:0]  root;
  logic [8:0]  rem;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  er;
    logic [8:0]  em;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [15:0] vy [13] = '{16'd0, 16'd65535, 16'd144, 16'd143, 16'd1, 16'd2, 16'd3,
                           16'd4, 16'd255, 16'd256, 16'd65025, 16'd65024, 16'd1000};
  logic [7:0]  vr [13] = '{8'd0, 8'd255, 8'd12, 8'd11, 8'd1, 8'd1, 8'd1,
                           8'd2, 8'd15, 8'd16, 8'd255, 8'd254, 8'd31};
  logic [8:0]  vm [13] = '{9'd0, 9'd510, 9'd0, 9'd22, 9'd0, 9'd1, 9'd2,
                           9'd0, 9'd30, 9'd0, 9'd0, 9'd508, 9'd39};

  isqrt_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .root  (root),
    .rem   (rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got pulse root=%0d rem=%0d expected none", root, rem);
      end else begin
        m_e = q.pop_front();
        chk("root", int'(root), int'(m_e.er));
        chk("rem", int'(rem), int'(m_e.em));
        chk("latency", cyc, m_e.due);
        chk("busy_at_done", int'(busy), 0);
        chk("invariant", int'(root) * int'(root) + int'(rem), int'(m_e.y));
      end
    end
  end

  task automatic issue(input logic [15:0] y, input logic [7:0] er, input logic [8:0] em);
    @(posedge clk);
    #1;
    start = 1'b1;
    Y     = y;
    q.push_back('{y, er, em, cyc + 9});
    @(posedge clk);
    #1;
    start = 1'b0;
    Y     = 16'($urandom);
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    Y     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_root", int'(root), 0);
    chk("reset_rem", int'(rem), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(vy[i], vr[i], vm[i]);
      wait_drain();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("hold_root", int'(root), 31);
    chk("hold_rem", int'(rem), 39);

    for (int a = 0; a < 256; a++) begin
      issue(16'(a * a), 8'(a), 9'd0);
      wait_drain();
    end

    // start re-asserted mid-calculation with a different Y must be ignored
    @(posedge clk);
    #1;
    start = 1'b1;
    Y     = 16'd100;
    q.push_back('{16'd100, 8'd10, 9'd0, cyc + 9});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    Y     = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    Y     = 16'hFFFF;
    wait_drain();
    repeat (12) @(posedge clk);

    // back-to-back: start held through the DONE edge
    @(posedge clk);
    #1;
    start = 1'b1;
    Y     = 16'd49;
    q.push_back('{16'd49, 8'd7, 9'd0, cyc + 9});
    q.push_back('{16'd50, 8'd7, 9'd1, cyc + 18});
    @(posedge clk);
    #1;
    Y = 16'd50;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    wait_drain();
    repeat (3) @(posedge clk);

    // reset mid-calculation (counter = 4) aborts the request
    @(posedge clk);
    #1;
    start = 1'b1;
    Y     = 16'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_root", int'(root), 0);
    chk("abort_rem", int'(rem), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    issue(16'd81, 8'd9, 9'd0);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
